// File: rtl/ltssm_pkg.sv
// ---------------------------------------------------------------------------
// ltssm_pkg: shared LTSSM substate/ordered-set codes, FSM states and timing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ltssm_pkg;

  localparam logic [3:0] SUB_DETECT_QUIET  = 4'd0;
  localparam logic [3:0] SUB_DETECT_ACTIVE = 4'd1;
  localparam logic [3:0] SUB_POLL_ACTIVE   = 4'd2;
  localparam logic [3:0] SUB_POLL_CONFIG   = 4'd3;
  localparam logic [3:0] SUB_CFG_LW_START  = 4'd4;
  localparam logic [3:0] SUB_CFG_LW_ACCEPT = 4'd5;
  localparam logic [3:0] SUB_CFG_LN_WAIT   = 4'd6;
  localparam logic [3:0] SUB_CFG_LN_ACCEPT = 4'd7;
  localparam logic [3:0] SUB_CFG_COMPLETE  = 4'd8;
  localparam logic [3:0] SUB_CFG_IDLE      = 4'd9;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_IDLE = 3'd3,
    OS_EIOS = 3'd4
  } os_type_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_TRAIL = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } fsm_state_e;

  localparam logic [10:0] POLL_TS1_MIN = 11'd1024;
  localparam logic [10:0] CFG_TS1_MIN  = 11'd16;
  localparam logic [4:0]  TRAIL_CNT    = 5'd16;

  localparam logic [5:0] TMR_DETECT_QUIET = 6'd12;
  localparam logic [5:0] TMR_POLL_ACTIVE  = 6'd24;
  localparam logic [5:0] TMR_POLL_CONFIG  = 6'd48;
  localparam logic [5:0] TMR_CFG          = 6'd24;
  localparam logic [5:0] TMR_SHORT        = 6'd2;

  typedef struct packed {
    logic [2:0] os_type;
    logic [5:0] timer;
    logic       elec_idle;
    logic       timer_en;
  } sub_cfg_t;

  // Transmit behaviour applied on entry to SEND for a given substate.
  function automatic sub_cfg_t sub_cfg(input logic [3:0] sub);
    sub_cfg_t c;
    c.os_type   = OS_NONE;
    c.timer     = 6'd0;
    c.elec_idle = 1'b0;
    c.timer_en  = 1'b1;
    case (sub)
      SUB_DETECT_QUIET:  begin c.timer = TMR_DETECT_QUIET; c.elec_idle = 1'b1; end
      SUB_DETECT_ACTIVE: begin c.elec_idle = 1'b1; c.timer_en = 1'b0; end
      SUB_POLL_ACTIVE:   begin c.os_type = OS_TS1; c.timer = TMR_POLL_ACTIVE; end
      SUB_POLL_CONFIG:   begin c.os_type = OS_TS2; c.timer = TMR_POLL_CONFIG; end
      SUB_CFG_LW_START, SUB_CFG_LW_ACCEPT, SUB_CFG_LN_ACCEPT:
                         begin c.os_type = OS_TS1; c.timer = TMR_CFG; end
      SUB_CFG_LN_WAIT:   begin c.os_type = OS_TS1; c.timer = TMR_SHORT; end
      SUB_CFG_COMPLETE:  begin c.os_type = OS_TS2; c.timer = TMR_SHORT; end
      SUB_CFG_IDLE:      begin c.os_type = OS_IDLE; c.timer = TMR_SHORT; end
      default:           c.timer_en = 1'b0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/master_tx_ltssm_os_counter.sv
// ---------------------------------------------------------------------------
// os_counter: saturating up-counter with synchronous clear; next_o is the
// value the counter takes at the coming edge. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module os_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign next_o = count_d;

endmodule

`default_nettype wire

// File: rtl/master_tx_ltssm.sv
// ---------------------------------------------------------------------------
// master_tx_ltssm: transmit-side LTSSM master sequencing ordered sets per
// substate. Optional MASTER_TX_FORCE_DETECT_EN adds forceDetect_i. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module master_tx_ltssm
  import ltssm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substate_i,
  input  logic       request_i,
  input  logic       osSent_i,
  input  logic       rxDone_i,
  input  logic       timeOut_i,
`ifdef MASTER_TX_FORCE_DETECT_EN
  input  logic       forceDetect_i,
`endif
  output logic [2:0] osType_o,
  output logic       txElecIdle_o,
  output logic       rxDetect_o,
  output logic [5:0] setTimer_o,
  output logic       enableTimer_o,
  output logic       resetTimer_o,
  output logic       finish_o,
  output logic [3:0] exitTo_o
);

  fsm_state_e state_q, state_d;
  logic [3:0] sub_q, sub_d;
  logic       start;
  logic       load;
  sub_cfg_t   cfg;
  logic [10:0] os_next;
  logic [4:0]  trail_next;

  logic [2:0] os_type_q;
  logic       elec_idle_q, rx_detect_q, en_timer_q, rst_timer_q, finish_q;
  logic [5:0] set_timer_q;
  logic [3:0] exit_to_q;
`ifdef MASTER_TX_FORCE_DETECT_EN
  logic       abort_q;
`endif

  assign load = (state_q == ST_IDLE) && request_i;
  assign cfg  = sub_cfg(sub_d);

  os_counter #(.WIDTH(11)) u_os_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (load | start),
    .inc_i  ((state_q == ST_SEND) && osSent_i),
    .next_o (os_next)
  );

  os_counter #(.WIDTH(5)) u_trail_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (load | start),
    .inc_i  ((state_q == ST_TRAIL) && osSent_i),
    .next_o (trail_next)
  );

  // Success conditions use the post-increment count so the pulse that
  // reaches the threshold finishes the substate in the same cycle.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request_i) begin
          sub_d = substate_i;
          if (substate_i > SUB_CFG_IDLE) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_SEND;
            start   = 1'b1;
          end
        end
      end
      ST_SEND: begin
        case (sub_q)
          SUB_DETECT_QUIET:  if (timeOut_i) state_d = ST_DONE;
          SUB_DETECT_ACTIVE: state_d = ST_DONE;
          SUB_POLL_ACTIVE: begin
            if (rxDone_i && (os_next >= POLL_TS1_MIN)) state_d = ST_DONE;
            else if (timeOut_i)                        state_d = ST_FAIL;
          end
          SUB_POLL_CONFIG, SUB_CFG_COMPLETE, SUB_CFG_IDLE: begin
            if (rxDone_i)       state_d = ST_TRAIL;
            else if (timeOut_i) state_d = ST_FAIL;
          end
          SUB_CFG_LW_START, SUB_CFG_LW_ACCEPT, SUB_CFG_LN_WAIT, SUB_CFG_LN_ACCEPT: begin
            if (rxDone_i && (os_next >= CFG_TS1_MIN)) state_d = ST_DONE;
            else if (timeOut_i)                       state_d = ST_FAIL;
          end
          default: state_d = ST_FAIL;
        endcase
      end
      ST_TRAIL: begin
        if (trail_next >= TRAIL_CNT) state_d = ST_DONE;
        else if (timeOut_i)          state_d = ST_FAIL;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MASTER_TX_FORCE_DETECT_EN
    if (abort_q) begin
      state_d = ST_SEND;
      sub_d   = SUB_DETECT_QUIET;
      start   = 1'b1;
    end
    if (forceDetect_i) begin
      state_d = ST_FAIL;
      start   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sub_q       <= SUB_DETECT_QUIET;
      os_type_q   <= OS_NONE;
      elec_idle_q <= 1'b1;
      rx_detect_q <= 1'b0;
      set_timer_q <= 6'd0;
      en_timer_q  <= 1'b0;
      rst_timer_q <= 1'b1;
      finish_q    <= 1'b0;
      exit_to_q   <= 4'd0;
`ifdef MASTER_TX_FORCE_DETECT_EN
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      rx_detect_q <= start && (sub_d == SUB_DETECT_ACTIVE);
      rst_timer_q <= !start;
      finish_q    <= 1'b0;
      exit_to_q   <= 4'd0;
`ifdef MASTER_TX_FORCE_DETECT_EN
      abort_q     <= forceDetect_i;
`endif
      if (load || start) set_timer_q <= cfg.timer;
      case (state_d)
        ST_IDLE: begin
          os_type_q   <= OS_NONE;
          elec_idle_q <= 1'b1;
          en_timer_q  <= 1'b0;
        end
        ST_SEND, ST_TRAIL: begin
          if (start) begin
            os_type_q   <= cfg.os_type;
            elec_idle_q <= cfg.elec_idle;
            en_timer_q  <= cfg.timer_en;
          end
        end
        ST_DONE: begin
          finish_q   <= 1'b1;
          exit_to_q  <= sub_q + 4'd1;
          en_timer_q <= 1'b0;
        end
        default: begin
`ifdef MASTER_TX_FORCE_DETECT_EN
          finish_q    <= !forceDetect_i;
`else
          finish_q    <= 1'b1;
`endif
          os_type_q   <= OS_EIOS;
          elec_idle_q <= 1'b0;
          en_timer_q  <= 1'b0;
        end
      endcase
    end
  end

  assign osType_o      = os_type_q;
  assign txElecIdle_o  = elec_idle_q;
  assign rxDetect_o    = rx_detect_q;
  assign setTimer_o    = set_timer_q;
  assign enableTimer_o = en_timer_q;
  assign resetTimer_o  = rst_timer_q;
  assign finish_o      = finish_q;
  assign exitTo_o      = exit_to_q;

endmodule

`default_nettype wire
